hs_pulse_scheduler: RTL and testbench

- Source-domain (clkA) front end for the handshake pulse synchronizer.
- Accepts single-cycle event strobes that may arrive back-to-back, faster than the handshake can carry them, and queues them as a saturating count.
- Issues exactly one single-cycle pulse to the synchronizer per queued event, waiting for each handshake to complete (busy rise then fall) plus a guard gap before issuing the next, so no event is lost or merged.

---
 rtl/hs_pulse_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_hs_pulse_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hs_pulse_scheduler.sv
// rtl/hs_pulse_scheduler.sv - clkA-side event queue and pulse pacer for the handshake pulse synchronizer (optional watchdog: HS_ACK_TIMEOUT_EN)
module hs_pulse_scheduler #(
  parameter int CNT_W          = 4,
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clkA,
  input  logic             rst_n,
  input  logic             evt_in,
  input  logic             hs_busy,
  input  logic             ovf_clr,
  output logic             hs_pulse,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             overflow,
  output logic             sched_busy,
  output logic             hs_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RISE,
    ST_WAIT_FALL,
    ST_GAP
  } state_e;

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             ovf_q, ovf_d;
  logic             pulse_q, pulse_d;
  logic             sbusy_q, sbusy_d;
  logic             issue;
  logic             drop;
  logic             wd_expire;
  logic             in_wait;

  assign in_wait = (state_q == ST_WAIT_RISE) || (state_q == ST_WAIT_FALL);

  // Handshake pacing: issue one pulse, track busy rise/fall, then hold off for the guard gap.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Registered count only; a stale busy (e.g. after reset) blocks issue.
        if ((cnt_q != '0) && !hs_busy) begin
          issue   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        if (wd_expire) begin
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end
        end else if (hs_busy) begin
          state_d = ST_WAIT_FALL;
        end
      end
      ST_WAIT_FALL: begin
        // A one-cycle busy pulse lands here and is already low: counts as a full handshake.
        if (wd_expire || !hs_busy) begin
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Saturating event queue: +1 per event, -1 per issued pulse, drop and flag at full scale.
  always_comb begin
    cnt_d = cnt_q;
    drop  = 1'b0;
    if (evt_in && !issue) begin
      if (cnt_q == CNT_MAX) begin
        drop = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!evt_in && issue) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    // A drop in the same cycle as a clear must stay visible.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    pulse_d = issue;
    sbusy_d = (state_d != ST_IDLE);
  end

  // State, queue and output registers.
  always_ff @(posedge clkA) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
      sbusy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ovf_q   <= ovf_d;
      pulse_q <= pulse_d;
      sbusy_q <= sbusy_d;
    end
  end

`ifdef HS_ACK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            tmo_q, tmo_d;

  // Expire on the TIMEOUT_CYCLES-th cycle spent waiting on this handshake.
  assign wd_expire = in_wait && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: restart per issued pulse, count only while waiting on busy.
  always_comb begin
    wd_d  = wd_q;
    tmo_d = tmo_q | wd_expire;
    if (issue) begin
      wd_d = '0;
    end else if (in_wait && !wd_expire) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  // Watchdog registers; the timeout flag is only cleared by reset.
  always_ff @(posedge clkA) begin
    if (!rst_n) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      tmo_q <= tmo_d;
    end
  end

  assign hs_timeout = tmo_q;
`else
  logic unused_wd_cfg;

  assign wd_expire     = 1'b0;
  assign hs_timeout    = 1'b0;
  assign unused_wd_cfg = (TIMEOUT_CYCLES != 0) & in_wait;
`endif

  assign hs_pulse    = pulse_q;
  assign pending_cnt = cnt_q;
  assign overflow    = ovf_q;
  assign sched_busy  = sbusy_q;

endmodule

// File: tb/tb_hs_pulse_scheduler.sv
// tb/tb_hs_pulse_scheduler.sv - randomized bench for hs_pulse_scheduler against a timestamp-based reference model
module tb_hs_pulse_scheduler;

  localparam int CNT_W = 4;
  localparam int GAP   = 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clkA    = 1'b0;
  logic             rst_n   = 1'b0;
  logic             evt_in  = 1'b0;
  logic             hs_busy = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             hs_pulse;
  logic [CNT_W-1:0] pending_cnt;
  logic             overflow;
  logic             sched_busy;
  logic             hs_timeout;

  hs_pulse_scheduler #(
    .CNT_W(CNT_W),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clkA(clkA),
    .rst_n(rst_n),
    .evt_in(evt_in),
    .hs_busy(hs_busy),
    .ovf_clr(ovf_clr),
    .hs_pulse(hs_pulse),
    .pending_cnt(pending_cnt),
    .overflow(overflow),
    .sched_busy(sched_busy),
    .hs_timeout(hs_timeout)
  );

  always #5 clkA = ~clkA;

  int total = 0;
  int bad   = 0;

  // reference model: queue depth, sticky flag, and handshake timestamps
  int m_cnt, m_ovf, m_pulse, m_sbusy, m_active, m_p, m_rise, m_fall;
  int cyc = 0;

  // synchronizer stand-in
  bit s_run = 1'b0;
  int s_start, s_end;
  int sd_lo = 3, sd_hi = 3, sl_lo = 8, sl_hi = 8;
  bit force_busy = 1'b0;
  int busy_run = 0;
  int pulses = 0;
  int peak = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step(input bit evt, input bit b, input bit clr, input bit rst);
    bit idle_c, issue, drop;
    if (!rst) begin
      m_cnt = 0; m_ovf = 0; m_pulse = 0; m_sbusy = 0;
      m_active = 0; m_p = -1; m_rise = -1; m_fall = -1;
      return;
    end
    idle_c = (m_active == 0) || (m_fall >= 0 && cyc >= m_fall + GAP + 1);
    if (m_active != 0 && idle_c) m_active = 0;
    if (m_active != 0) begin
      if (m_rise < 0 && cyc > m_p && b) m_rise = cyc;
      else if (m_rise >= 0 && m_fall < 0 && cyc > m_rise && !b) m_fall = cyc;
    end
    issue = idle_c && (m_cnt > 0) && !b;
    m_pulse = issue ? 1 : 0;
    if (issue) begin
      m_active = 1; m_p = cyc + 1; m_rise = -1; m_fall = -1;
    end
    drop = 1'b0;
    if (evt && !issue) begin
      if (m_cnt == CMAX) drop = 1'b1;
      else m_cnt++;
    end else if (!evt && issue) begin
      m_cnt--;
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_sbusy = (m_active != 0 && !(m_fall >= 0 && cyc + 1 >= m_fall + GAP + 1)) ? 1 : 0;
  endtask

  task automatic tick(input bit evt, input bit clr, input bit rst);
    bit b;
    b = force_busy || (s_run && cyc >= s_start && cyc < s_end);
    rst_n   = rst;
    evt_in  = evt;
    ovf_clr = clr;
    hs_busy = b;
    if (b) busy_run++;
    else busy_run = 0;
    model_step(evt, b, clr, rst);
    @(posedge clkA);
    @(negedge clkA);
    cyc++;
    chk("hs_pulse", 32'(hs_pulse), 32'(m_pulse));
    chk("pending_cnt", 32'(pending_cnt), 32'(m_cnt));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("sched_busy", 32'(sched_busy), 32'(m_sbusy));
`ifndef HS_ACK_TIMEOUT_EN
    chk("hs_timeout", 32'(hs_timeout), 32'(0));
`endif
    if (hs_pulse === 1'b1) pulses++;
    if (int'(pending_cnt) > peak) peak = int'(pending_cnt);
    if (s_run && cyc >= s_end) s_run = 1'b0;
    if (!s_run && hs_pulse === 1'b1) begin
      s_run   = 1'b1;
      s_start = cyc + int'($urandom_range(sd_hi, sd_lo));
      s_end   = s_start + int'($urandom_range(sl_hi, sl_lo));
    end
  endtask

  task automatic wait_quiet(input int maxc);
    int n;
    n = 0;
    while (!(m_cnt == 0 && m_sbusy == 0 && m_pulse == 0 && !s_run && !force_busy) && n < maxc) begin
      tick(1'b0, 1'b0, 1'b1);
      n++;
    end
    chk("quiet_reached", 32'(n < maxc), 32'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit cyc=%0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int pct;
    bit e, c, r;

    // reset state
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("rst_pending", 32'(pending_cnt), 32'(0));
    chk("rst_pulse", 32'(hs_pulse), 32'(0));
    chk("rst_sbusy", 32'(sched_busy), 32'(0));
    tick(1'b0, 1'b0, 1'b1);
    chk("no_pulse_after_release", 32'(hs_pulse), 32'(0));

    // single event: pulse exactly two cycles after the strobe
    pulses = 0;
    tick(1'b1, 1'b0, 1'b1);
    chk("single_cnt_n1", 32'(pending_cnt), 32'(1));
    chk("single_pulse_n1", 32'(hs_pulse), 32'(0));
    tick(1'b0, 1'b0, 1'b1);
    chk("single_pulse_n2", 32'(hs_pulse), 32'(1));
    chk("single_cnt_n2", 32'(pending_cnt), 32'(0));
    wait_quiet(200);
    chk("single_pulses", 32'(pulses), 32'(1));

    // burst of five
    pulses = 0;
    peak   = 0;
    repeat (5) tick(1'b1, 1'b0, 1'b1);
    wait_quiet(400);
    chk("burst_peak", 32'(peak), 32'(4));
    chk("burst_pulses", 32'(pulses), 32'(5));
    chk("burst_ovf", 32'(overflow), 32'(0));

    // saturation while busy is held
    force_busy = 1'b1;
    repeat (17) tick(1'b1, 1'b0, 1'b1);
    chk("sat_cnt", 32'(pending_cnt), 32'(CMAX));
    chk("sat_ovf", 32'(overflow), 32'(1));
    tick(1'b1, 1'b1, 1'b1);
    chk("sat_set_wins", 32'(overflow), 32'(1));
    tick(1'b0, 1'b1, 1'b1);
    chk("sat_clear", 32'(overflow), 32'(0));
    force_busy = 1'b0;
    wait_quiet(1000);

    // event coinciding with issue
    force_busy = 1'b1;
    repeat (2) tick(1'b1, 1'b0, 1'b1);
    force_busy = 1'b0;
    tick(1'b1, 1'b0, 1'b1);
    chk("simul_cnt", 32'(pending_cnt), 32'(2));
    chk("simul_pulse", 32'(hs_pulse), 32'(1));
    tick(1'b0, 1'b0, 1'b1);
    chk("simul_pulse_one_cycle", 32'(hs_pulse), 32'(0));
    wait_quiet(400);

    // reset while waiting for busy to fall
    repeat (3) tick(1'b1, 1'b0, 1'b1);
    begin
      int n;
      n = 0;
      while (busy_run < 2 && n < 40) begin
        tick(1'b0, 1'b0, 1'b1);
        n++;
      end
      chk("midrst_reached_wait_fall", 32'(n < 40), 32'(1));
    end
    tick(1'b0, 1'b0, 1'b0);
    chk("midrst_pending", 32'(pending_cnt), 32'(0));
    chk("midrst_pulse", 32'(hs_pulse), 32'(0));
    chk("midrst_sbusy", 32'(sched_busy), 32'(0));
    chk("midrst_ovf", 32'(overflow), 32'(0));
    pulses = 0;
    repeat (30) tick(1'b0, 1'b0, 1'b1);
    chk("midrst_no_pulse", 32'(pulses), 32'(0));
    wait_quiet(200);

    // randomized traffic
    sd_lo = 1; sd_hi = 4; sl_lo = 1; sl_hi = 8;
    pct = 30;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) pct = (($urandom_range(0, 2) == 0) ? 10 : (($urandom_range(0, 1) == 0) ? 40 : 90));
      if ($urandom_range(0, 199) == 0) force_busy = ~force_busy;
      e = ($urandom_range(0, 99) < pct);
      c = ($urandom_range(0, 29) == 0);
      r = ($urandom_range(0, 399) != 0);
      tick(e, c, r);
    end
    force_busy = 1'b0;
    wait_quiet(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
